pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The module SHALL have parameter WIDTH, default 267, meaning payload width in bits, excluding the valid bit.
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning the number of buffer entries; legal values are powers of two from 2 to 16.
REQ-003 The module SHALL have parameter CW, default $clog2(DEPTH+1), meaning the occupancy count width.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-low.
REQ-006 Port i_data  input  WIDTH  payload from the upstream stage.
REQ-007 Port i_v  input  1  upstream payload valid.
REQ-008 Port o_ready  output  1  buffer can accept a payload this cycle.
REQ-009 Port i_stall  input  1  downstream stage cannot consume the head this cycle.
REQ-010 Port i_flush  input  1  invalidate all buffered payloads (branch mispredict or exception).
REQ-011 Port o_data  output  WIDTH  head payload.
REQ-012 Port o_v  output  1  head payload valid.
REQ-013 Port o_count  output  CW  number of occupied entries.
REQ-014 Port o_full  output  1  o_count == DEPTH.
REQ-015 Port o_empty  output  1  o_count == 0.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer with a write pointer and a read pointer, each log2(DEPTH) bits wide, plus a CW-bit count register.
REQ-017 Push SHALL occur when i_v && o_ready && !i_flush; the payload is written at the write pointer, and the write pointer increments modulo DEPTH.
REQ-018 Pop SHALL occur when o_v && !i_stall && !i_flush; the read pointer increments modulo DEPTH.
REQ-019 On push without pop, count SHALL increase by 1; on pop without push, count SHALL decrease by 1; on simultaneous push and pop, count SHALL be unchanged.
REQ-020 o_ready SHALL equal !o_full, derived from the registered count only, with no combinational path from i_stall.
REQ-021 o_v SHALL equal !o_empty.
REQ-022 o_data SHALL be the entry at the read pointer when o_v=1, and all-zero when o_v=0.
REQ-023 Latency SHALL be one cycle: a payload pushed at edge N is visible on o_data/o_v after edge N when the buffer was empty.
REQ-024 Order SHALL be strict FIFO; no payload is duplicated or reordered.
REQ-025 When full and a pop occurs, o_ready SHALL stay 0 in that cycle; the freed entry becomes available after the edge.
REQ-026 i_flush SHALL take priority over push and pop: at the next edge count, write pointer and read pointer all become 0, and any i_data presented in the flush cycle is dropped.
REQ-027 i_stall SHALL never alter buffered contents; with i_stall held high, o_data and o_v remain stable.
REQ-028 Write pointer and read pointer wrap-around SHALL be seamless; the full and empty states are distinguished by count, not by pointer equality.
REQ-029 Entries not written since reset or flush SHALL never appear on o_data while o_v=1.

Reset
REQ-030 While rst=0, asynchronously: count=0 and both pointers=0, giving o_v=0, o_data=0, o_empty=1, o_full=0, o_count=0, o_ready=1.
REQ-031 Entry storage need not be reset.
REQ-032 Deassertion of rst SHALL be sampled at a clock edge; the first push is accepted at the first edge after rst=1.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Push 0x11, 0x22, 0x33, 0x44 with i_stall=1 -> o_full=1, o_ready=0, o_count=4, o_data=0x11 held stable.
REQ-035 From the full state, release i_stall for 4 cycles with i_v=0 -> o_data sequence 0x11, 0x22, 0x33, 0x44, then o_v=0, o_data=0x00, o_empty=1.
REQ-036 Continuous push and pop over 10 cycles (values 0x01..0x0A), i_stall=0 -> output 0x01..0x0A in order with one-cycle latency, o_count constant at 1, pointers wrap twice.
REQ-037 Occupancy 3, assert i_flush with i_v=1, i_data=0x55 -> next cycle o_count=0, o_v=0; 0x55 is never output.
REQ-038 Occupancy 2, drive rst=0 between clock edges -> o_v=0 and o_count=0 immediately; after release, push 0x7E -> o_data=0x7E one cycle later.
REQ-039 Full buffer, pop and attempted push (i_v=1, o_ready=0) in the same cycle -> payload not stored, o_count=3 after the edge, o_ready=1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline buffer between two stages: circular FIFO with
// stall back-pressure and flush-on-redirect.
module pipe_stage_buf #(
  parameter int WIDTH = 267,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_v,
  output logic             o_ready,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_v,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Flags come from the registered count only, so ready never
  // depends on the downstream stall in the same cycle.
  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_ready = !o_full;
  assign o_v     = !o_empty;
  assign o_count = count;
  assign o_data  = o_v ? mem[rd_ptr] : '0;

  assign push = i_v && o_ready && !i_flush;
  assign pop  = o_v && !i_stall && !i_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is not reset; count gating keeps stale
  // entries off o_data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized + directed bench for pipe_stage_buf (WIDTH=8, DEPTH=4)
// with a queue-based scoreboard.
module tb_pipe_stage_buf;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          i_v = 1'b0;
  logic          o_ready;
  logic          i_stall = 1'b0;
  logic          i_flush = 1'b0;
  logic [W-1:0]  o_data;
  logic          o_v;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] sb[$];
  bit           p_push, p_pop, p_flush;
  logic [W-1:0] p_data;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_v(i_v),
    .o_ready(o_ready), .i_stall(i_stall), .i_flush(i_flush),
    .o_data(o_data), .o_v(o_v), .o_count(o_count),
    .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the model, then decide what
  // the coming edge does from the model's own occupancy.
  always @(negedge clk) begin
    int n;
    n = sb.size();
    chk("count", int'(o_count), n);
    chk("valid", int'(o_v), int'(n > 0));
    chk("full", int'(o_full), int'(n == D));
    chk("empty", int'(o_empty), int'(n == 0));
    chk("ready", int'(o_ready), int'(n < D));
    if (n > 0) chk("head", int'(o_data), int'(sb[0]));
    else       chk("zero_data", int'(o_data), 0);
    p_flush = rst && i_flush;
    p_pop   = rst && !i_flush && !i_stall && (n > 0);
    p_push  = rst && !i_flush && i_v && (n < D);
    p_data  = i_data;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (p_flush) sb.delete();
      else begin
        if (p_pop) void'(sb.pop_front());
        if (p_push) sb.push_back(p_data);
      end
    end
    p_push = 0; p_pop = 0; p_flush = 0;
  end

  always @(negedge rst) begin
    sb.delete();
    p_push = 0; p_pop = 0; p_flush = 0;
  end

  task automatic cyc(input logic v, input logic [W-1:0] d,
                     input logic st, input logic fl);
    i_v = v; i_data = d; i_stall = st; i_flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] vals[4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(o_count), 0);
    chk("rst_ready", int'(o_ready), 1);
    rst = 1'b1;

    // Fill under stall, head held
    for (int i = 0; i < 4; i++) cyc(1'b1, vals[i], 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fill_full", int'(o_full), 1);
    chk("fill_ready", int'(o_ready), 0);
    chk("fill_head", int'(o_data), 8'h11);
    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_seq", int'(o_data), int'(vals[i]));
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("drain_empty", int'(o_empty), 1);
    chk("drain_data", int'(o_data), 0);

    // Streaming, occupancy held at 1
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, W'(i), 1'b0, 1'b0);
      chk("stream_cnt", int'(o_count), 1);
      chk("stream_data", int'(o_data), i);
    end
    idle(2);

    // Flush drops in-flight payload
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hA0 + W'(i), 1'b1, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b1);
    chk("flush_cnt", int'(o_count), 0);
    chk("flush_v", int'(o_v), 0);
    idle(2);

    // Asynchronous reset between edges
    cyc(1'b1, 8'h61, 1'b1, 1'b0);
    cyc(1'b1, 8'h62, 1'b1, 1'b0);
    i_v = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_v", int'(o_v), 0);
    chk("arst_cnt", int'(o_count), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("arst_push", int'(o_data), 8'h7E);
    idle(2);

    // Full: pop plus rejected push
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hC0 + W'(i), 1'b1, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("full_pop_cnt", int'(o_count), 3);
    chk("full_pop_rdy", int'(o_ready), 1);
    idle(4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
      end
      cyc(1'($urandom_range(0, 99) < 60), W'($urandom),
          1'($urandom_range(0, 99) < 35),
          1'($urandom_range(0, 99) < 3));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
